// File: rtl/rhd2000_data_model_pkg.sv
// Shared constants for the RHD2000 SPI data model:
// command opcodes, result codes and register/ROM address map.
package rhd2000_data_model_pkg;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_MISC    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [15:0] RESULT_MIDSCALE = 16'h8000;

    localparam int          RAM_DEPTH = 18;
    localparam logic [5:0]  RAM_LAST  = 6'd17;

    localparam logic [5:0] ROM_I        = 6'd40;
    localparam logic [5:0] ROM_N1       = 6'd41;
    localparam logic [5:0] ROM_T        = 6'd42;
    localparam logic [5:0] ROM_A        = 6'd43;
    localparam logic [5:0] ROM_N2       = 6'd44;
    localparam logic [5:0] ROM_REVISION = 6'd60;
    localparam logic [5:0] ROM_UNIPOLAR = 6'd61;
    localparam logic [5:0] ROM_CHANNELS = 6'd62;
    localparam logic [5:0] ROM_ID       = 6'd63;

    function automatic logic [7:0] intan_byte(input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = 8'h49;
            3'd1:    b = 8'h4E;
            3'd2:    b = 8'h54;
            3'd3:    b = 8'h41;
            3'd4:    b = 8'h4E;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rhd2000_data_model_regfile.sv
// 18x8 register RAM plus the ID and chip-info ROMs behind
// a single combinational read port and one synchronous write port.
module rhd2000_regfile
    import rhd2000_data_model_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int REVISION = 1,
    parameter int UNIPOLAR = 1,
    parameter int ID       = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [5:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [5:0] i_raddr,
    output logic [7:0] o_rdata,
    output logic       o_aux
);

    logic [7:0] r_ram [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                r_ram[i] <= 8'h00;
            end
        end else if (i_we && i_waddr <= RAM_LAST) begin
            r_ram[i_waddr[4:0]] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = 8'h00;
        if (i_raddr <= RAM_LAST) begin
            o_rdata = r_ram[i_raddr[4:0]];
        end else begin
            case (i_raddr)
                ROM_I, ROM_N1, ROM_T, ROM_A, ROM_N2:
                    o_rdata = intan_byte(3'(i_raddr - ROM_I));
                ROM_REVISION: o_rdata = 8'(REVISION);
                ROM_UNIPOLAR: o_rdata = 8'(UNIPOLAR);
                ROM_CHANNELS: o_rdata = 8'(CHANNELS);
                ROM_ID:       o_rdata = 8'(ID);
                default:      o_rdata = 8'h00;
            endcase
        end
    end

    assign o_aux = r_ram[3][0];

endmodule

// File: rtl/rhd2000_data_model.sv
// RHD2000 amplifier seen from its SPI port: 16-bit command frames,
// results returned two frames later through a two-word pipeline.
module rhd2000_data_model
    import rhd2000_data_model_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int REVISION = 1,
    parameter int UNIPOLAR = 1,
    parameter int ID       = 1
) (
    input  logic         sClk,
    input  logic         reset,
    input  logic [511:0] analogIn,
    input  logic         nCs,
    input  logic         mosi,
    output logic         miso,
    output logic         aux
);

    logic [3:0]  r_count;
    logic [15:0] r_rx;
    logic [15:0] r_tx;
    logic [15:0] r_pend;

    logic [15:0] w_cmd;
    logic [1:0]  w_op;
    logic [5:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_last;
    logic        w_we;
    logic [7:0]  w_rdata;
    logic [15:0] w_result;

    assign w_cmd  = {r_rx[14:0], mosi};
    assign w_op   = w_cmd[15:14];
    assign w_addr = w_cmd[13:8];
    assign w_data = w_cmd[7:0];
    assign w_last = !nCs && (r_count == 4'd15);
    assign w_we   = w_last && (w_op == OP_WRITE);

    rhd2000_regfile #(
        .CHANNELS (CHANNELS),
        .REVISION (REVISION),
        .UNIPOLAR (UNIPOLAR),
        .ID       (ID)
    ) u_regfile (
        .i_clk   (sClk),
        .i_rst   (reset),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_data),
        .i_raddr (w_addr),
        .o_rdata (w_rdata),
        .o_aux   (aux)
    );

    // Channels at or beyond 32 never index the bus, even if CHANNELS is larger.
    always_comb begin
        w_result = RESULT_MIDSCALE;
        unique case (w_op)
            OP_CONVERT: begin
                if (!w_addr[5] && ({26'd0, w_addr} < 32'(CHANNELS)))
                    w_result = analogIn[{w_addr[4:0], 4'b0000} +: 16];
            end
            OP_MISC:  w_result = RESULT_MIDSCALE;
            OP_WRITE: w_result = {8'hFF, w_data};
            OP_READ:  w_result = {8'h00, w_rdata};
        endcase
    end

    always_ff @(posedge sClk) begin
        if (reset) begin
            r_count <= 4'd0;
            r_rx    <= 16'h0000;
            r_tx    <= 16'h0000;
            r_pend  <= 16'h0000;
        end else if (!nCs) begin
            r_count <= r_count + 4'd1;
            r_rx    <= w_cmd;
            if (w_last) begin
                r_tx   <= r_pend;
                r_pend <= w_result;
            end
        end
    end

    assign miso = nCs ? 1'b0 : r_tx[4'd15 - r_count];

endmodule

// File: tb/tb_rhd2000_data_model.sv
// Randomized SPI-frame bench for rhd2000_data_model against a
// frame-level reference model with a two-deep result history.
module tb_rhd2000_data_model;

    logic         sClk = 1'b0;
    logic         reset;
    logic [511:0] analogIn;
    logic         nCs;
    logic         mosi;
    logic         miso;
    logic         aux;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_ram [18];
    logic [15:0] m_tx;
    logic [15:0] m_pend;
    logic [15:0] got;

    rhd2000_data_model dut (
        .sClk     (sClk),
        .reset    (reset),
        .analogIn (analogIn),
        .nCs      (nCs),
        .mosi     (mosi),
        .miso     (miso),
        .aux      (aux)
    );

    always #5 sClk = ~sClk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_value(input int a);
        string s;
        s = "INTAN";
        if (a <= 17) return {8'h00, m_ram[a]};
        if (a >= 40 && a <= 44) return {8'h00, 8'(s[a-40])};
        if (a == 60) return 16'd1;
        if (a == 61) return 16'd1;
        if (a == 62) return 16'd32;
        if (a == 63) return 16'd1;
        return 16'h0000;
    endfunction

    task automatic model_cmd(input logic [15:0] cmd, output logic [15:0] r);
        int a;
        a = int'(cmd[13:8]);
        case (cmd[15:14])
            2'b00: r = (a < 32) ? analogIn[a*16 +: 16] : 16'h8000;
            2'b01: r = 16'h8000;
            2'b10: begin
                r = {8'hFF, cmd[7:0]};
                if (a <= 17) m_ram[a] = cmd[7:0];
            end
            default: r = rd_value(a);
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 18; i++) m_ram[i] = 8'h00;
        m_tx   = 16'h0000;
        m_pend = 16'h0000;
    endtask

    // Shift one frame; got holds what miso presented, exp is frame N-2.
    task automatic frame(input string tag, input logic [15:0] cmd);
        logic [15:0] exp;
        logic [15:0] r;
        nCs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mosi = cmd[15-i];
            #1 got[15-i] = miso;
            @(posedge sClk);
            #1;
        end
        nCs  = 1'b1;
        mosi = 1'b0;
        exp  = m_tx;
        m_tx = m_pend;
        model_cmd(cmd, r);
        m_pend = r;
        chk(tag, got, exp);
        chk({tag, "_aux"}, {15'd0, aux}, {15'd0, m_ram[3][0]});
        @(posedge sClk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge sClk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] cmd;
        logic [7:0]  d;
        reset = 1'b1;
        nCs   = 1'b1;
        mosi  = 1'b0;
        for (int k = 0; k < 32; k++) analogIn[k*16 +: 16] = 16'(k + 1);
        repeat (2) @(posedge sClk);
        #1 reset = 1'b0;
        model_reset();

        chk("rst_miso", {15'd0, miso}, 16'h0000);
        chk("rst_aux", {15'd0, aux}, 16'h0000);
        nCs = 1'b0;
        #1 chk("rst_miso_cs", {15'd0, miso}, 16'h0000);
        nCs = 1'b1;

        for (int c = 0; c < 34; c++) frame("convert", {2'b00, 6'(c), 8'h00});

        frame("calibrate", 16'h5500);
        for (int i = 0; i < 10; i++) frame("clear", 16'h6A00);

        for (int a = 0; a < 18; a++) begin
            d = 8'($urandom);
            frame("ram_wr", {2'b10, 6'(a), d});
            frame("ram_rd", {2'b11, 6'(a), 8'h00});
            frame("ram_d1", 16'h6A00);
            chk("ram_echo", got, {8'hFF, d});
            frame("ram_d2", 16'h6A00);
            chk("ram_read", got, {8'h00, d});
        end

        for (int a = 40; a < 64; a++) begin
            if (a > 44 && a < 60) continue;
            d = 8'($urandom);
            frame("rom_wr", {2'b10, 6'(a), d});
            frame("rom_rd", {2'b11, 6'(a), 8'h00});
            frame("rom_d1", 16'h6A00);
            frame("rom_d2", 16'h6A00);
        end

        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 32; k++) analogIn[k*16 +: 16] = 16'($urandom);
            cmd = 16'($urandom);
            if (cmd[15:14] != 2'b00) cmd[13] = 1'b0;
            frame("random", cmd);
        end

        frame("aux_wr", 16'h8301);
        chk("aux_set", {15'd0, aux}, 16'h0001);
        do_reset();
        chk("aux_clr", {15'd0, aux}, 16'h0000);
        frame("post_rst0", 16'hC300);
        chk("post_rst0_z", got, 16'h0000);
        frame("post_rst1", 16'h6A00);
        chk("post_rst1_z", got, 16'h0000);
        frame("post_rst2", 16'h6A00);
        chk("rd3_after_rst", got, 16'h0000);

        frame("pre_mid", 16'h8255);
        frame("pre_mid2", 16'hC200);
        nCs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom);
            @(posedge sClk);
            #1;
        end
        do_reset();
        nCs = 1'b1;
        mosi = 1'b0;
        @(posedge sClk);
        #1;
        frame("mid_rst0", 16'hC200);
        frame("mid_rst1", 16'h6A00);
        frame("mid_rst2", 16'h6A00);
        chk("mid_rst_ram", got, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
